// File: rtl/fwd_pkg.sv
// Shared constants and types for the forwarding/hazard unit.
// Operand select encodings and the multiply-stall FSM state type.
package fwd_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_ALU = 2'b10;

  typedef enum logic {
    IDLE      = 1'b0,
    MULT_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding select: EX/MEM wins over MEM/WB, and register 0
// is never forwarded.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_reg_write,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_reg_write,
  output logic [1:0]        sel
);

  logic ex_mem_hit;
  logic mem_wb_hit;

  assign ex_mem_hit = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == src);
  assign mem_wb_hit = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == src);

  always_comb begin
    sel = FWD_REG;
    if (ex_mem_hit)      sel = FWD_ALU;
    else if (mem_wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding plus load-use / 2-cycle-multiply stall control.
// state     | meaning
// IDLE      | normal issue; a multiply in EX triggers a one-cycle stall
// MULT_WAIT | second multiply cycle; the held multiply is ignored here
module forwarding_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [REG_AW-1:0] id_ex_rs1,
  input  logic [REG_AW-1:0] id_ex_rs2,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_is_mult,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_reg_write,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              id_ex_write_en,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mult_busy,
  output logic [CNT_W-1:0]  stall_count
);

  state_t state;
  state_t state_next;
  logic   mult_stall;
  logic   load_use;

  fwd_select #(.REG_AW(REG_AW)) u_sel_a (
    .src              (id_ex_rs1),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .sel              (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_sel_b (
    .src              (id_ex_rs2),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .sel              (fwd_b)
  );

  assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:      state_next = id_ex_is_mult ? MULT_WAIT : IDLE;
      MULT_WAIT: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // mult_stall is gated by reset so the pipeline runs freely while held in reset.
  always_comb begin
    mult_stall     = arst_n && (state == IDLE) && id_ex_is_mult;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    id_ex_write_en = 1'b1;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    if (mult_stall) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_write_en = 1'b0;
      ex_mem_flush   = 1'b1;
    end else if (load_use) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
    end
  end

  assign mult_busy = (state == MULT_WAIT);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_count <= '0;
    end else if ((mult_stall || load_use) && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
